// File: rtl/pwm_generator.sv
// PWM output stage: turns a duty (percent) / period (clocks) pair into a glitch-free
// PWM pin. New settings are computed serially and only take effect on a period wrap.
module pwm_generator #(
  parameter int CNT_W     = 24,
  parameter int DUTY_W    = 8,
  parameter int DUTY_FULL = 100
) (
  input  logic              CLK,
  input  logic              Rst,
  input  logic [DUTY_W-1:0] Duty,
  input  logic [CNT_W-1:0]  Count_P,
  output logic              PWM_Out,
  output logic              Period_Start,
  output logic              Busy
);

  localparam int PROD_W = CNT_W + DUTY_W;
  localparam int DCNT_W = $clog2(PROD_W);
  localparam logic [DUTY_W-1:0] FULL     = DUTY_W'(DUTY_FULL);
  localparam logic [DUTY_W:0]   DIVISOR  = (DUTY_W+1)'(DUTY_FULL);
  localparam logic [DCNT_W-1:0] DIV_LAST = DCNT_W'(PROD_W-1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} eng_state_t;
  eng_state_t state;

  logic [DUTY_W-1:0] duty_clamped;
  logic [DUTY_W-1:0] samp_d;
  logic [CNT_W-1:0]  samp_p;
  logic [PROD_W-1:0] dq;
  logic [DUTY_W-1:0] rem;
  logic [DUTY_W-1:0] rem_next;
  logic [DUTY_W:0]   shifted;
  logic [DUTY_W:0]   diff;
  logic              q_bit;
  logic [DCNT_W-1:0] div_cnt;
  logic [CNT_W-1:0]  pend_p;
  logic [CNT_W-1:0]  pend_th;
  logic              pend_valid;
  logic [CNT_W-1:0]  act_p;
  logic [CNT_W-1:0]  act_th;
  logic [CNT_W-1:0]  cnt;

  always_comb begin
    duty_clamped = (Duty > FULL) ? FULL : Duty;
  end

  // One restoring-division step: dq shifts the dividend out and the quotient in.
  always_comb begin
    shifted  = {rem, dq[PROD_W-1]};
    q_bit    = (shifted >= DIVISOR);
    diff     = shifted - DIVISOR;
    rem_next = DUTY_W'(q_bit ? diff : shifted);
  end

  always_ff @(posedge CLK) begin
    if (Rst) begin
      state        <= IDLE;
      Busy         <= 1'b0;
      PWM_Out      <= 1'b0;
      Period_Start <= 1'b0;
      samp_d       <= '0;
      samp_p       <= '0;
      dq           <= '0;
      rem          <= '0;
      div_cnt      <= '0;
      pend_p       <= '0;
      pend_th      <= '0;
      pend_valid   <= 1'b0;
      act_p        <= '0;
      act_th       <= '0;
      cnt          <= '0;
    end else begin
      // Period counter; a pending setting is only adopted at a wrap or while stopped.
      if (act_p == '0) begin
        cnt <= '0;
        if (pend_valid) begin
          act_p      <= pend_p;
          act_th     <= pend_th;
          pend_valid <= 1'b0;
        end
      end else if (cnt == act_p - 1'b1) begin
        cnt <= '0;
        if (pend_valid) begin
          act_p      <= pend_p;
          act_th     <= pend_th;
          pend_valid <= 1'b0;
        end
      end else begin
        cnt <= cnt + 1'b1;
      end

      PWM_Out      <= (act_p != '0) && (cnt < act_th);
      Period_Start <= (act_p != '0) && (cnt == '0);

      // Engine sits after the counter so a DONE write wins over a same-cycle load/clear.
      case (state)
        IDLE: begin
          if ((duty_clamped != samp_d) || (Count_P != samp_p)) begin
            samp_d <= duty_clamped;
            samp_p <= Count_P;
            state  <= MUL;
            Busy   <= 1'b1;
          end
        end
        MUL: begin
          dq      <= PROD_W'(samp_p) * PROD_W'(samp_d);
          rem     <= '0;
          div_cnt <= '0;
          state   <= DIV;
        end
        DIV: begin
          rem     <= rem_next;
          dq      <= {dq[PROD_W-2:0], q_bit};
          div_cnt <= div_cnt + 1'b1;
          if (div_cnt == DIV_LAST) state <= DONE;
        end
        DONE: begin
          pend_p     <= samp_p;
          pend_th    <= dq[CNT_W-1:0];
          pend_valid <= 1'b1;
          state      <= IDLE;
          Busy       <= 1'b0;
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_generator.sv
// Directed bench for pwm_generator: expected {PWM_Out, Period_Start} per cycle are queued
// from the duty/period settings and popped against the DUT one cycle at a time.
module tb_pwm_generator;

  localparam int CNT_W  = 24;
  localparam int DUTY_W = 8;

  logic              CLK = 1'b0;
  logic              Rst;
  logic [DUTY_W-1:0] Duty;
  logic [CNT_W-1:0]  Count_P;
  logic              PWM_Out;
  logic              Period_Start;
  logic              Busy;

  int n_cmp = 0;
  int n_err = 0;
  logic [1:0] exp_q[$];  // {pwm, period_start}

  int   hi;
  int   w;
  int   busy_hi;
  int   rises;
  logic busy_prev;

  pwm_generator #(.CNT_W(CNT_W), .DUTY_W(DUTY_W), .DUTY_FULL(100)) dut (
    .CLK          (CLK),
    .Rst          (Rst),
    .Duty         (Duty),
    .Count_P      (Count_P),
    .PWM_Out      (PWM_Out),
    .Period_Start (Period_Start),
    .Busy         (Busy)
  );

  // Clock and sampling: inputs driven and outputs sampled on the falling edge.
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_period(input int p, input int th);
    for (int k = 0; k < p; k++)
      exp_q.push_back({(k < th) ? 1'b1 : 1'b0, (k == 0) ? 1'b1 : 1'b0});
  endtask

  task automatic push_const(input int n, input logic [1:0] v);
    for (int k = 0; k < n; k++) exp_q.push_back(v);
  endtask

  task automatic sb_step(input string tag, input int idx);
    logic [1:0] e;
    e = exp_q.pop_front();
    check($sformatf("%s[%0d]", tag, idx), {30'd0, PWM_Out, Period_Start}, {30'd0, e});
    @(negedge CLK);
  endtask

  task automatic wait_busy_done(output int hi_cycles);
    hi_cycles = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge CLK);
      if (Busy) hi_cycles++;
      else if (hi_cycles > 0) break;
    end
  endtask

  task automatic wait_ps(output int waited);
    waited = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge CLK);
      waited++;
      if (Period_Start) break;
    end
  endtask

  initial begin
    Rst = 1'b1; Duty = '0; Count_P = '0;
    repeat (3) @(negedge CLK);
    check("rst_pwm", PWM_Out, 0);
    check("rst_ps", Period_Start, 0);
    check("rst_busy", Busy, 0);
    Rst = 1'b0;
    repeat (5) @(negedge CLK);
    check("idle_pwm", PWM_Out, 0);
    check("idle_ps", Period_Start, 0);
    check("idle_busy", Busy, 0);

    // 50 % of 10 from stopped: 34 busy cycles, load one cycle later, then 5 high / 5 low.
    Duty = 8'd50; Count_P = 24'd10;
    wait_busy_done(hi);
    check("s2_busy_len", hi, 34);
    @(negedge CLK);
    check("s2_ps_load_cycle", Period_Start, 0);
    wait_ps(w);
    check("s2_first_ps", w, 1);
    repeat (3) push_period(10, 5);
    for (int i = 0; exp_q.size() > 0; i++) sb_step("s2", i);

    // 30 % of 7 -> threshold 2; ready after 35 cycles, adopted at the wrap 40 cycles in.
    push_const(0, 2'b00);
    repeat (4) push_period(10, 5);
    repeat (3) push_period(7, 2);
    for (int i = 0; exp_q.size() > 0; i++) begin
      if (i == 0) begin Duty = 8'd30; Count_P = 24'd7; end
      sb_step("s3", i);
    end

    // 100 % then 0 % of 20: each switch lands on a period boundary.
    repeat (6) push_period(7, 2);
    repeat (4) push_period(20, 20);
    repeat (2) push_period(20, 0);
    for (int i = 0; exp_q.size() > 0; i++) begin
      if (i == 0) begin Duty = 8'd100; Count_P = 24'd20; end
      if (i == 82) Duty = 8'd0;
      sb_step("s4", i);
    end

    // Period 100: 50 -> 80 mid-period, then 60 and 70 five cycles apart (only 70 lands).
    repeat (2) push_period(20, 0);
    push_period(100, 50);
    repeat (2) push_period(100, 80);
    repeat (2) push_period(100, 70);
    busy_hi = 0; rises = 0; busy_prev = 1'b0;
    for (int i = 0; exp_q.size() > 0; i++) begin
      if (i == 0) begin Duty = 8'd50; Count_P = 24'd100; end
      if (i == 80) Duty = 8'd80;
      if (i == 240) Duty = 8'd60;
      if (i == 245) Duty = 8'd70;
      if (i >= 240 && i < 340) begin
        if (Busy) busy_hi++;
        if (Busy && !busy_prev) rises++;
      end
      busy_prev = Busy;
      sb_step("s5", i);
    end
    check("s5_busy_hi", busy_hi, 68);
    check("s5_busy_runs", rises, 2);

    // Duty 150 clamps to 100 and must not retrigger the engine once sampled.
    push_period(100, 70);
    repeat (2) push_period(100, 100);
    busy_hi = 0;
    for (int i = 0; exp_q.size() > 0; i++) begin
      if (i == 0) Duty = 8'd150;
      if (Busy) busy_hi++;
      sb_step("s6", i);
    end
    check("s6_busy_hi", busy_hi, 34);

    // Count_P = 0: current period completes, then output stays low with no Period_Start.
    push_period(100, 100);
    push_const(60, 2'b00);
    for (int i = 0; exp_q.size() > 0; i++) begin
      if (i == 0) Count_P = 24'd0;
      sb_step("s7", i);
    end

    // P = 1: Period_Start every cycle; high only at 100 %, low at 99 %.
    Count_P = 24'd1;
    wait_busy_done(hi);
    check("p1_busy_len", hi, 34);
    @(negedge CLK);
    check("p1_ps_load_cycle", Period_Start, 0);
    wait_ps(w);
    check("p1_first_ps", w, 1);
    push_const(37, 2'b11);
    push_const(10, 2'b01);
    for (int i = 0; exp_q.size() > 0; i++) begin
      if (i == 0) Duty = 8'd99;
      sb_step("p1", i);
    end

    // Reset in the middle of a division, then the held inputs are recomputed.
    Duty = 8'd50; Count_P = 24'd10;
    repeat (10) @(negedge CLK);
    check("s8_busy_pre", Busy, 1);
    check("s8_ps_pre", Period_Start, 1);
    Rst = 1'b1;
    @(negedge CLK);
    check("s8_rst_pwm", PWM_Out, 0);
    check("s8_rst_ps", Period_Start, 0);
    check("s8_rst_busy", Busy, 0);
    @(negedge CLK);
    Rst = 1'b0;
    wait_busy_done(hi);
    check("s8_busy_len", hi, 34);
    @(negedge CLK);
    check("s8_ps_load_cycle", Period_Start, 0);
    wait_ps(w);
    check("s8_first_ps", w, 1);
    repeat (2) push_period(10, 5);
    for (int i = 0; exp_q.size() > 0; i++) sb_step("s8", i);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pwm_generator.md
# pwm_generator

Consumes the duty (percent) and period (clock count) settings produced by the button-adjust stage and drives a single PWM output pin. Computes the high-time threshold `Count_P*Duty/100` with a multi-cycle multiply/divide engine. The new setting takes effect only on a period boundary, so the output never emits a truncated or glitched period.

## Interface
- `CNT_W`, default 24: width of the period count.
- `DUTY_W`, default 8: width of the duty input.
- `DUTY_FULL`, default 100: duty value meaning 100 %.

Ports:
- `CLK`  in  1  system clock; one clock domain.
- `Rst`  in  1  synchronous, active-high reset.
- `Duty`  in  DUTY_W  requested duty in percent; values above DUTY_FULL are clamped to DUTY_FULL.
- `Count_P`  in  CNT_W  requested period in CLK cycles; 0 means stopped.
- `PWM_Out`  out  1  registered PWM output.
- `Period_Start`  out  1  one-cycle pulse on the first cycle of each period.
- `Busy`  out  1  high while the threshold engine is computing.

## Operation
- **Reset:**
  - `PWM_Out`, `Period_Start` and `Busy` are 0.
  - Active period, active threshold, sampled Duty, sampled Count_P and the pending-valid flag are 0.
  - Period counter is 0, and the block is in the stopped state.
- **Sampling:**
  - When the engine is IDLE and the clamped Duty or Count_P differs from the last sampled pair, the block samples both and enters MUL.
  - Inputs are held static by the upstream stage between button events.
- **Engine states** (IDLE → MUL → DIV → DONE → IDLE):
  - MUL, 1 cycle: product = `Count_P*Duty`, width CNT_W+DUTY_W (32).
  - DIV, 32 cycles: restoring shift-subtract division by DUTY_FULL. Quotient = floor(product/100), which is always ≤ Count_P.
  - DONE, 1 cycle: writes the pending period and threshold and sets pending-valid. A newer result overwrites an unapplied one.
  - `Busy` = 1 in MUL, DIV and DONE.
- **Inputs changing during computation:** the sample in flight completes. The mismatch is seen on return to IDLE and a new computation starts, so the last value always wins.
- **Period counter:**
  - Counts 0 … P−1 of the active period P, then wraps to 0.
  - At the wrap (counter = P−1), when pending-valid = 1: load the active P and threshold from pending and clear pending-valid.
  - When stopped (active P = 0): pending is applied on the cycle after DONE, and counting starts at 0.
- **Output:**
  - `PWM_Out` is registered: (counter < threshold).
  - `Period_Start` is registered: (counter == 0 and active P ≠ 0).
  - Threshold 0 gives constant low; threshold = P gives constant high.
- **Active P = 0:** counter held at 0, `PWM_Out` = 0, no `Period_Start`.
- **P = 1:** `Period_Start` is high every cycle, and `PWM_Out` = 1 only when Duty = 100.

## Timing
- Latency from an input change to pending-valid: 35 cycles. This is 1 sample cycle, 1 MUL, 32 DIV and 1 DONE.
- The new setting applies at the next period wrap after pending-valid.
- Both outputs lag the internal counter by one cycle. `Period_Start` coincides with the first high cycle of `PWM_Out` whenever the threshold is ≥ 1.
- Every period issued is exactly P cycles long and is never cut short by a setting change.
- Pending-valid set on the same cycle as the wrap: the load waits for the following wrap. Pending is checked on the registered flag.
- `Rst` asserted mid-operation:
  - All state returns to reset values on the next edge, and the engine computation is abandoned.
  - After release, the held inputs are resampled.

## Test plan
- Reset, then Duty = 50, Count_P = 10 → `Busy` for 34 cycles. Then a repeating pattern: 5 cycles high, 5 low, `Period_Start` every 10 cycles.
- Duty = 30, Count_P = 7 → threshold 2: 2 high / 5 low per 7-cycle period.
- Duty = 100, then Duty = 0 (Count_P = 20) → constant high, then constant low. Each switch occurs exactly on a `Period_Start` boundary and no period is shortened.
- Running at Count_P = 100, Duty = 50, change to Duty = 80 at counter 40 → the current period finishes with 50 high. The next period has 80 high.
- Duty changed twice within 10 cycles (50 → 60 → 70) → only 70 % is ever applied. `Busy` stays high for two back-to-back computations.
- Duty = 150 → behaves as 100. Count_P = 0 → `PWM_Out` low and no `Period_Start` after the current period ends. `Rst` mid-DIV → outputs 0 next cycle and recomputation after release.
